// File: rtl/extram_vga_arbiter.sv
// Shares one async 512 KiB x8 SRAM between a VGA read port (absolute priority) and an 8-bit Wishbone slave.
// Latency: VGA data 1 clock after request; Wishbone ack 2 clocks after stb plus 1 per VGA-occupied cycle.
// Backpressure: VGA never waits; CPU stalls in PEND while I_vga_req=1. EXTRAM_PROTECT_EN blocks writes >= PROTECT_BASE.
module extram_vga_arbiter #(
    parameter int                ADDR_W       = 19,
    parameter logic [ADDR_W-1:0] PROTECT_BASE = 19'h40000
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_vga_req,
    input  logic [ADDR_W-1:0] I_vga_adr,
    output logic [7:0]        O_vga_dat,
    input  logic [ADDR_W-1:0] I_wb_adr,
    input  logic [7:0]        I_wb_dat,
    input  logic              I_wb_stb,
    input  logic              I_wb_we,
    output logic              O_wb_ack,
    output logic [7:0]        O_wb_dat,
    output logic [ADDR_W-1:0] O_sram_adr,
    output logic [7:0]        O_sram_dat,
    input  logic [7:0]        I_sram_dat,
    output logic              O_sram_dat_oe,
    output logic              O_sram_ce_n,
    output logic              O_sram_oe_n,
    output logic              O_sram_we_n,
    output logic              O_prot_viol
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

`ifdef EXTRAM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_adr;
    logic [7:0]        lat_dat;
    logic              lat_we;
    logic              cpu_slot;
    logic              wr_block;

    // The CPU only gets the SRAM in a PEND cycle that VGA leaves free.
    assign cpu_slot = (state == S_PEND) && !I_vga_req;
    assign wr_block = PROT_EN && lat_we && (lat_adr >= PROTECT_BASE);

    always_comb begin
        O_sram_adr    = lat_adr;
        O_sram_dat    = lat_dat;
        O_sram_dat_oe = 1'b0;
        O_sram_ce_n   = 1'b1;
        O_sram_oe_n   = 1'b1;
        O_sram_we_n   = 1'b1;
        if (I_vga_req) begin
            O_sram_adr  = I_vga_adr;
            O_sram_ce_n = 1'b0;
            O_sram_oe_n = 1'b0;
        end else if (cpu_slot) begin
            if (lat_we) begin
                // A blocked write still burns the slot, but the chip stays deselected.
                if (!wr_block) begin
                    O_sram_dat_oe = 1'b1;
                    O_sram_ce_n   = 1'b0;
                    O_sram_we_n   = 1'b0;
                end
            end else begin
                O_sram_ce_n = 1'b0;
                O_sram_oe_n = 1'b0;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state       <= S_IDLE;
            lat_adr     <= '0;
            lat_dat     <= 8'h00;
            lat_we      <= 1'b0;
            O_vga_dat   <= 8'h00;
            O_wb_ack    <= 1'b0;
            O_wb_dat    <= 8'h00;
            O_prot_viol <= 1'b0;
        end else begin
            if (I_vga_req)
                O_vga_dat <= I_sram_dat;
            O_wb_ack <= cpu_slot;
            if (cpu_slot && !lat_we)
                O_wb_dat <= I_sram_dat;
            if (cpu_slot && wr_block)
                O_prot_viol <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (I_wb_stb) begin
                        lat_adr <= I_wb_adr;
                        lat_dat <= I_wb_dat;
                        lat_we  <= I_wb_we;
                        state   <= S_PEND;
                    end
                end
                S_PEND: if (!I_vga_req) state <= S_ACK;
                S_ACK:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
